branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage dynamic branch predictor that closes the loop with the execute-stage branch resolution logic. It predicts direction and target for conditional branches at fetch, using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Execute-stage resolution (taken flag, actual target, predicted bits carried down the pipe) trains it and flags mispredicts to the hazard unit. It also keeps branch and mispredict performance counters.

## Interface
- DATA_WIDTH, 32, width of PC and target
- INDEX_BITS, 4, log2 of entry count (16 entries)
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- PCF_i  in  DATA_WIDTH  fetch-stage PC to look up
- PredictTaken_o  out  1  predicted taken for PCF_i
- PredictTarget_o  out  DATA_WIDTH  predicted target; 0 when no hit
- UpdateEn_i  in  1  resolved conditional branch in execute this cycle
- UpdatePC_i  in  DATA_WIDTH  PC of the resolved branch
- UpdateTaken_i  in  1  actual outcome from branch resolution
- UpdateTarget_i  in  DATA_WIDTH  actual branch target (PC + imm)
- UpdatePredTaken_i  in  1  PredictTaken_o value carried with this branch
- UpdatePredTarget_i  in  DATA_WIDTH  PredictTarget_o value carried with this branch
- Mispredict_o  out  1  redirect/flush request for this cycle
- BranchCount_o  out  32  resolved conditional branches since reset
- MispredictCount_o  out  32  mispredicts since reset

## Operation
- Index = PC[INDEX_BITS+1:2]. Tag = PC[DATA_WIDTH-1:INDEX_BITS+2].
- Each entry holds valid, tag, 2-bit counter and target.
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Lookup:
  - hit = valid && tag match.
  - PredictTaken_o = hit && ctr[1].
  - PredictTarget_o = entry target on hit, else 0.
- Update when UpdateEn_i, on a hit:
  - taken: ctr increments, saturating at ST; target is rewritten with UpdateTarget_i.
  - not taken: ctr decrements, saturating at SNT; target is left unchanged.
- Update when UpdateEn_i, on a miss:
  - taken: allocate or overwrite the entry. valid=1, new tag, ctr=WT, target=UpdateTarget_i.
  - not taken: no table change.
- Mispredict_o = UpdateEn_i && ((UpdateTaken_i != UpdatePredTaken_i) || (UpdateTaken_i && UpdatePredTarget_i != UpdateTarget_i)).
- Counters:
  - BranchCount_o increments on UpdateEn_i.
  - MispredictCount_o increments on Mispredict_o.
  - Both saturate at 32'hFFFF_FFFF.
- UpdateEn_i low: all Update* inputs are ignored and Mispredict_o = 0.

## Timing
- Lookup is combinational from PCF_i: zero-cycle latency, the result is valid in the same cycle.
- Table writes take effect at the rising edge after UpdateEn_i. There is no write-to-read bypass: a lookup at the same index in the update cycle sees the old entry.
- Mispredict_o is combinational in the update cycle. Performance counters update at the next edge.
- Reset, at the edge where rst_i = 1:
  - all valid = 0, all ctr = WNT, all targets = 0;
  - both performance counters = 0.
- Reset outputs:
  - PredictTaken_o = 0 and PredictTarget_o = 0 for any PC.
  - Mispredict_o = 0 only while UpdateEn_i = 0, since it is combinational on the Update* inputs.
- Reset asserted in the same cycle as UpdateEn_i: reset wins, no entry is written and no counter is incremented.
- Aliasing: two branches with the same index and different tags thrash. Last taken writer owns the entry, by design.

## Structure
- Package bp_pkg:
  - ctr_t enum (SNT, WNT, WT, ST).
  - btb_entry_t struct (valid, tag, ctr, target).
  - Tag/index width localparams derived from DATA_WIDTH and INDEX_BITS.
- Sub-module sat_ctr2: next-state function of a 2-bit saturating counter, taking ctr_t and a taken bit. Purely combinational; used in the update path.
- The table is a flop array (2^INDEX_BITS entries), not inferred RAM, because of the asynchronous read and whole-table reset.

## Test plan
- Reset, then lookup PCF_i=0x0000_0040 -> PredictTaken_o=0, PredictTarget_o=0, both counts 0.
- Untrained branch at PC 0x40:
  - Stimulus: UpdateEn_i=1, UpdateTaken_i=1, UpdateTarget_i=0x80, PredTaken=0.
  - Response: Mispredict_o=1.
  - Next cycle: lookup 0x40 gives taken, target 0x80, MispredictCount_o=1.
- Saturation down at PC 0x40:
  - Stimulus: three not-taken updates, then a further one.
  - Response: counter goes ST→… never below SNT. Lookup is not taken after the 2nd. Target 0x80 is retained.
- Alias eviction:
  - Stimulus: taken update at 0x40, then taken update at 0x440 (same index, INDEX_BITS=4) with target 0x500.
  - Response: lookup 0x40 misses (0, 0); lookup 0x440 gives taken, 0x500.
- Same-cycle update and lookup:
  - Stimulus: taken update at 0x40 with PCF_i=0x40, from reset.
  - Response: prediction 0 in that cycle, taken the next cycle.
  - Stimulus: rst_i together with UpdateEn_i.
  - Response: nothing is written.
- Target mismatch:
  - Stimulus: UpdateTaken_i=1, PredTaken=1, PredTarget=0x80, UpdateTarget_i=0x84.
  - Response: Mispredict_o=1 and the entry target becomes 0x84.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and widths for the fetch-stage branch predictor
package bp_pkg;

    localparam int BP_DATA_WIDTH = 32;
    localparam int BP_INDEX_BITS = 4;
    localparam int BP_ENTRIES    = 1 << BP_INDEX_BITS;
    localparam int BP_TAG_BITS   = BP_DATA_WIDTH - BP_INDEX_BITS - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_BITS-1:0]   tag;
        ctr_t                     ctr;
        logic [BP_DATA_WIDTH-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/sat_ctr2.sv
// rtl/sat_ctr2.sv - next state of a 2-bit saturating direction counter
module sat_ctr2
    import bp_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_taken,
    output ctr_t o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        case (i_ctr)
            SNT:     o_ctr = i_taken ? WNT : SNT;
            WNT:     o_ctr = i_taken ? WT  : SNT;
            WT:      o_ctr = i_taken ? ST  : WNT;
            ST:      o_ctr = i_taken ? ST  : WT;
            default: o_ctr = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB predictor with execute-stage training
// and branch/mispredict performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = BP_DATA_WIDTH,
    parameter int INDEX_BITS = BP_INDEX_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] PCF_i,
    output logic                  PredictTaken_o,
    output logic [DATA_WIDTH-1:0] PredictTarget_o,
    input  logic                  UpdateEn_i,
    input  logic [DATA_WIDTH-1:0] UpdatePC_i,
    input  logic                  UpdateTaken_i,
    input  logic [DATA_WIDTH-1:0] UpdateTarget_i,
    input  logic                  UpdatePredTaken_i,
    input  logic [DATA_WIDTH-1:0] UpdatePredTarget_i,
    output logic                  Mispredict_o,
    output logic [31:0]           BranchCount_o,
    output logic [31:0]           MispredictCount_o
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;

    btb_entry_t r_btb [ENTRIES];
    logic [31:0] r_branch_count;
    logic [31:0] r_mispredict_count;

    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    btb_entry_t            w_lk_entry;
    logic                  w_lk_hit;
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    btb_entry_t            w_up_entry;
    logic                  w_up_hit;
    ctr_t                  w_up_ctr;
    logic                  w_unused;

    // Word-aligned PCs: the two low bits never take part in index or tag.
    assign w_unused = ^{PCF_i[1:0], UpdatePC_i[1:0]};

    assign w_lk_idx   = PCF_i[INDEX_BITS+1:2];
    assign w_lk_tag   = PCF_i[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_lk_entry = r_btb[w_lk_idx];
    assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

    assign PredictTaken_o  = w_lk_hit && w_lk_entry.ctr[1];
    assign PredictTarget_o = w_lk_hit ? w_lk_entry.target : '0;

    assign w_up_idx   = UpdatePC_i[INDEX_BITS+1:2];
    assign w_up_tag   = UpdatePC_i[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_up_entry = r_btb[w_up_idx];
    assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

    sat_ctr2 u_sat_ctr2 (
        .i_ctr   (w_up_entry.ctr),
        .i_taken (UpdateTaken_i),
        .o_ctr   (w_up_ctr)
    );

    assign Mispredict_o = UpdateEn_i &&
        ((UpdateTaken_i != UpdatePredTaken_i) ||
         (UpdateTaken_i && (UpdatePredTarget_i != UpdateTarget_i)));

    assign BranchCount_o     = r_branch_count;
    assign MispredictCount_o = r_mispredict_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, ctr: WNT, target: '0};
            end
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (UpdateEn_i) begin
                if (w_up_hit) begin
                    r_btb[w_up_idx].ctr <= w_up_ctr;
                    if (UpdateTaken_i) begin
                        r_btb[w_up_idx].target <= UpdateTarget_i;
                    end
                end else if (UpdateTaken_i) begin
                    // Taken miss claims the slot; any aliasing owner is evicted.
                    r_btb[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag, ctr: WT,
                                         target: UpdateTarget_i};
                end
            end
            if (UpdateEn_i && (r_branch_count != 32'hFFFF_FFFF)) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (Mispredict_o && (r_mispredict_count != 32'hFFFF_FFFF)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcf;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];
    longint      m_bc;
    longint      m_mc;

    branch_predictor dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .PCF_i              (pcf),
        .PredictTaken_o     (pred_taken),
        .PredictTarget_o    (pred_target),
        .UpdateEn_i         (upd_en),
        .UpdatePC_i         (upd_pc),
        .UpdateTaken_i      (upd_taken),
        .UpdateTarget_i     (upd_target),
        .UpdatePredTaken_i  (upd_pred_taken),
        .UpdatePredTarget_i (upd_pred_target),
        .Mispredict_o       (mispredict),
        .BranchCount_o      (branch_count),
        .MispredictCount_o  (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_predict(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        int idx;
        idx = int'(pc[5:2]);
        if (m_valid[idx] && m_tag[idx] == (pc >> 6)) begin
            t  = (m_ctr[idx] >= 2);
            tg = m_tgt[idx];
        end else begin
            t  = 1'b0;
            tg = 32'h0;
        end
    endfunction

    function automatic bit model_mispredict();
        if (!upd_en) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_pred_target != upd_target);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_tag[i]   = 32'h0;
                m_ctr[i]   = 1;
                m_tgt[i]   = 32'h0;
            end
            m_bc = 0;
            m_mc = 0;
        end else if (upd_en) begin
            int idx;
            bit mp;
            mp  = model_mispredict();
            idx = int'(upd_pc[5:2]);
            if (m_valid[idx] && m_tag[idx] == (upd_pc >> 6)) begin
                if (upd_taken) begin
                    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_tgt[idx] = upd_target;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = upd_pc >> 6;
                m_ctr[idx]   = 2;
                m_tgt[idx]   = upd_target;
            end
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit          et;
            logic [31:0] etg;
            model_predict(pcf, et, etg);
            check("pred_taken", {31'b0, pred_taken}, {31'b0, et});
            check("pred_target", pred_target, etg);
            check("mispredict", {31'b0, mispredict}, {31'b0, model_mispredict()});
            check("branch_count", branch_count, m_bc[31:0]);
            check("mispredict_count", mispredict_count, m_mc[31:0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        upd_en = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h0; pcf = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg,
                       input bit pt, input logic [31:0] ptg);
        upd_en = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tg;
        upd_pred_taken = pt; upd_pred_target = ptg;
    endtask

    task automatic lit_pred(input string name, input bit t, input logic [31:0] tg);
        @(negedge clk);
        #1;
        check({name, "_taken"}, {31'b0, pred_taken}, {31'b0, t});
        check({name, "_target"}, pred_target, tg);
    endtask

    logic [31:0] pool_pc;
    bit          mt;
    logic [31:0] mtg;

    initial begin
        rst = 1'b1;
        idle(32'h40);
        cyc(); cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        lit_pred("reset", 1'b0, 32'h0);
        check("reset_bc", branch_count, 32'd0);
        check("reset_mc", mispredict_count, 32'd0);
        cyc();

        // untrained taken branch, lookup in the same cycle sees the old entry
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        lit_pred("same_cycle", 1'b0, 32'h0);
        check("untrained_mp", {31'b0, mispredict}, 32'd1);
        cyc();
        idle(32'h40);
        lit_pred("trained", 1'b1, 32'h80);
        check("trained_mc", mispredict_count, 32'd1);
        check("trained_bc", branch_count, 32'd1);
        cyc();

        // WT -> ST, then walk down and past SNT
        upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80); cyc();
        upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80); cyc();
        upd(32'h40, 1'b0, 32'h80, 1'b1, 32'h80); cyc();
        idle(32'h40);
        lit_pred("down2", 1'b0, 32'h80);
        cyc();
        upd(32'h40, 1'b0, 32'h80, 1'b0, 32'h80); cyc();
        upd(32'h40, 1'b0, 32'h80, 1'b0, 32'h80); cyc();
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h80); cyc();
        idle(32'h40);
        lit_pred("no_underflow", 1'b0, 32'h80);
        cyc();

        // alias eviction
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h80); cyc();
        upd(32'h440, 1'b1, 32'h500, 1'b0, 32'h0); cyc();
        idle(32'h40);
        lit_pred("evicted", 1'b0, 32'h0);
        cyc();
        idle(32'h440);
        lit_pred("owner", 1'b1, 32'h500);
        cyc();

        // target mismatch retrains the target
        upd(32'h440, 1'b1, 32'h504, 1'b1, 32'h500);
        @(negedge clk); #1;
        check("target_mp", {31'b0, mispredict}, 32'd1);
        cyc();
        upd(32'h440, 1'b1, 32'h504, 1'b1, 32'h504);
        @(negedge clk); #1;
        check("correct_mp", {31'b0, mispredict}, 32'd0);
        cyc();
        idle(32'h440);
        lit_pred("retarget", 1'b1, 32'h504);
        cyc();

        // reset wins over a same-cycle update
        rst = 1'b1;
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        cyc();
        rst = 1'b0;
        idle(32'h40);
        lit_pred("rst_wins", 1'b0, 32'h0);
        check("rst_wins_bc", branch_count, 32'd0);
        check("rst_wins_mc", mispredict_count, 32'd0);
        cyc();

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(199) == 0);
            pool_pc = {24'h0, 2'($urandom_range(3)), 4'($urandom_range(15)), 2'b00};
            pcf = {24'h0, 2'($urandom_range(3)), 4'($urandom_range(15)), 2'b00};
            upd_en = ($urandom_range(3) != 0);
            upd_pc = pool_pc;
            upd_taken = $urandom_range(1);
            case ($urandom_range(2))
                0:       upd_target = 32'h80;
                1:       upd_target = 32'h84;
                default: upd_target = $urandom & 32'h0000_0FFC;
            endcase
            model_predict(pool_pc, mt, mtg);
            if ($urandom_range(3) != 0) begin
                upd_pred_taken  = mt;
                upd_pred_target = mtg;
            end else begin
                upd_pred_taken  = $urandom_range(1);
                upd_pred_target = $urandom_range(1) ? upd_target : ($urandom & 32'h0000_0FFC);
            end
            cyc();
        end

        rst = 1'b0;
        idle(32'h0);
        cyc();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
